// File: rtl/sp_pkg.sv
// Shared types, default parameters and helpers for the self-purging reintegrator.
// Imported by the top level and by the per-copy controller.
package sp_pkg;

  typedef enum logic [1:0] {
    StActive  = 2'b00,
    StPurged  = 2'b01,
    StRetired = 2'b10
  } copy_state_e;

  // Upper bound on copy count accepted by popcount().
  localparam int unsigned MaxCopies = 32;

  localparam int unsigned DefN         = 6;
  localparam int unsigned DefAgreeCyc  = 8;
  localparam int unsigned DefMaxRetry  = 3;
  localparam int unsigned DefMinActive = 3;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefNActiveW = cnt_width(DefN + 1);
  localparam int unsigned DefAgreeW   = cnt_width(DefAgreeCyc);
  localparam int unsigned DefRetryW   = cnt_width(DefMaxRetry + 1);

  function automatic int unsigned popcount(input logic [MaxCopies-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MaxCopies; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/self_purging_reintegrator_if.sv
// Bundle of the redundant-copy inputs and voted/status outputs.
// master drives copy outputs and controls; slave is the reintegrator.
interface self_purging_reintegrator_if #(
  parameter int unsigned N = 6
) ();
  localparam int unsigned NW = (N + 1 <= 1) ? 1 : $clog2(N + 1);

  logic          enable;
  logic          clear_retired;
  logic [N-1:0]  mod_sum;
  logic [N-1:0]  mod_cout;
  logic          sum;
  logic          cout;
  logic [N-1:0]  active;
  logic [N-1:0]  retired;
  logic [NW-1:0] n_active;
  logic          fail;

  modport master (
    output enable, clear_retired, mod_sum, mod_cout,
    input  sum, cout, active, retired, n_active, fail
  );

  modport slave (
    input  enable, clear_retired, mod_sum, mod_cout,
    output sum, cout, active, retired, n_active, fail
  );
endinterface

// File: rtl/sp_copy_ctrl.sv
// Per-copy purge/reinstate/retire state machine with its agree-run and
// purge-count counters.
module sp_copy_ctrl
  import sp_pkg::*;
#(
  parameter int unsigned AGREE_CYC = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic disagree,
  output logic active,
  output logic retired
);
  localparam int unsigned AW = cnt_width(AGREE_CYC);
  localparam int unsigned RW = cnt_width(MAX_RETRY + 1);

  localparam logic [AW-1:0] AgreeLast = AW'(AGREE_CYC - 1);
  localparam logic [RW-1:0] RetryLast = RW'(MAX_RETRY - 1);

  copy_state_e   state_q, state_d;
  logic [AW-1:0] agree_q, agree_d;
  logic [RW-1:0] retry_q, retry_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StActive;
      agree_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      agree_q <= agree_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    agree_d = agree_q;
    retry_d = retry_q;
    // Release of a retired copy wins even when enable is low.
    if (clear && (state_q == StRetired)) begin
      state_d = StPurged;
      agree_d = '0;
      retry_d = '0;
    end else if (enable) begin
      case (state_q)
        StActive: begin
          if (disagree) begin
            if (retry_q == RetryLast) begin
              if (clear) begin
                state_d = StPurged;
                agree_d = '0;
                retry_d = '0;
              end else begin
                state_d = StRetired;
              end
            end else begin
              state_d = StPurged;
              agree_d = '0;
              retry_d = retry_q + RW'(1);
            end
          end
        end
        StPurged: begin
          if (disagree) begin
            agree_d = '0;
          end else if (agree_q == AgreeLast) begin
            state_d = StActive;
            agree_d = '0;
          end else begin
            agree_d = agree_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active  = (state_q == StActive);
    retired = (state_q == StRetired);
  end

endmodule

// File: rtl/self_purging_reintegrator.sv
// Majority voter over the active redundant copies, with per-copy purge,
// reinstatement after a clean agreement run, and retirement of repeat offenders.
module self_purging_reintegrator
  import sp_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned AGREE_CYC  = DefAgreeCyc,
  parameter int unsigned MAX_RETRY  = DefMaxRetry,
  parameter int unsigned MIN_ACTIVE = DefMinActive
) (
  input logic                      clk,
  input logic                      rst_n,
  self_purging_reintegrator_if.slave bus
);
  localparam int unsigned NW = cnt_width(N + 1);

  logic [N-1:0]  active;
  logic [N-1:0]  retired;
  logic [N-1:0]  disagree;
  logic [NW-1:0] n_active;
  int unsigned   sum_cnt, cout_cnt;
  logic          v_sum, v_cout;
  logic          sum_q, cout_q;

  // n_active and fail decode only the registered copy states, so they change
  // exclusively at the clock edge like the state they summarise.
  always_comb begin
    n_active = NW'(popcount(MaxCopies'(active)));
    sum_cnt  = popcount(MaxCopies'(bus.mod_sum & active));
    cout_cnt = popcount(MaxCopies'(bus.mod_cout & active));
    // Strict majority: ties and an empty active set both vote 0.
    v_sum    = (2 * sum_cnt) > 32'(n_active);
    v_cout   = (2 * cout_cnt) > 32'(n_active);
  end

  for (genvar i = 0; i < N; i++) begin : g_copy
    assign disagree[i] = (bus.mod_sum[i] != v_sum) || (bus.mod_cout[i] != v_cout);

    sp_copy_ctrl #(
      .AGREE_CYC (AGREE_CYC),
      .MAX_RETRY (MAX_RETRY)
    ) u_ctrl (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (bus.enable),
      .clear    (bus.clear_retired),
      .disagree (disagree[i]),
      .active   (active[i]),
      .retired  (retired[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= v_sum;
      cout_q <= v_cout;
    end
  end

  always_comb begin
    bus.sum      = sum_q;
    bus.cout     = cout_q;
    bus.active   = active;
    bus.retired  = retired;
    bus.n_active = n_active;
    bus.fail     = (32'(n_active) < MIN_ACTIVE);
  end

endmodule

// File: tb/tb_self_purging_reintegrator.sv
// Directed plan scenarios followed by randomized fault injection, all checked
// against a per-copy behavioural model of the purge/reinstate/retire rules.
module tb_self_purging_reintegrator;
  localparam int N          = 6;
  localparam int AGREE_CYC  = 8;
  localparam int MAX_RETRY  = 3;
  localparam int MIN_ACTIVE = 3;
  localparam logic [N-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  self_purging_reintegrator_if #(.N(N)) bus ();

  self_purging_reintegrator #(
    .N          (N),
    .AGREE_CYC  (AGREE_CYC),
    .MAX_RETRY  (MAX_RETRY),
    .MIN_ACTIVE (MIN_ACTIVE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 = active, 1 = purged, 2 = retired.
  int   st[N];
  int   ag[N];
  int   rt[N];
  logic exp_sum, exp_cout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] mask_of(input int s);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (st[i] == s);
    return m;
  endfunction

  function automatic int count_active();
    int c = 0;
    for (int i = 0; i < N; i++) if (st[i] == 0) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      st[i] = 0;
      ag[i] = 0;
      rt[i] = 0;
    end
    exp_sum  = 1'b0;
    exp_cout = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] ms, input logic [N-1:0] mc,
                            input logic en, input logic clr);
    int  ns = 0, nc = 0, na;
    logic vs, vc, dis;
    na = count_active();
    for (int i = 0; i < N; i++) begin
      if (st[i] == 0 && ms[i]) ns++;
      if (st[i] == 0 && mc[i]) nc++;
    end
    vs = (2 * ns > na);
    vc = (2 * nc > na);
    exp_sum  = vs;
    exp_cout = vc;
    for (int i = 0; i < N; i++) begin
      dis = (ms[i] != vs) || (mc[i] != vc);
      if (clr && st[i] == 2) begin
        st[i] = 1; ag[i] = 0; rt[i] = 0;
      end else if (en) begin
        if (st[i] == 0 && dis) begin
          if (rt[i] + 1 == MAX_RETRY) begin
            if (clr) begin
              st[i] = 1; ag[i] = 0; rt[i] = 0;
            end else begin
              st[i] = 2;
            end
          end else begin
            st[i] = 1; rt[i]++; ag[i] = 0;
          end
        end else if (st[i] == 1) begin
          if (dis) ag[i] = 0;
          else if (ag[i] == AGREE_CYC - 1) begin
            st[i] = 0; ag[i] = 0;
          end else ag[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    int na;
    na = count_active();
    check("sum", 32'(bus.sum), 32'(exp_sum));
    check("cout", 32'(bus.cout), 32'(exp_cout));
    check("active", 32'(bus.active), 32'(mask_of(0)));
    check("retired", 32'(bus.retired), 32'(mask_of(2)));
    check("n_active", 32'(bus.n_active), na);
    check("fail", 32'(bus.fail), 32'(na < MIN_ACTIVE));
  endtask

  task automatic step(input logic [N-1:0] ms, input logic [N-1:0] mc,
                      input logic en, input logic clr);
    bus.mod_sum       = ms;
    bus.mod_cout      = mc;
    bus.enable        = en;
    bus.clear_retired = clr;
    @(posedge clk);
    model_edge(ms, mc, en, clr);
    #1;
    compare_all();
  endtask

  task automatic agree_run(input int cycles);
    for (int k = 0; k < cycles; k++) step(ALL1, ALL1, 1'b1, 1'b0);
  endtask

  // Reset is asserted mid-cycle so its asynchronous effect is observed before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] ms, mc, stuck;
    logic ts, tc, en, clr;
    int err_pct;

    rst_n             = 1'b0;
    bus.enable        = 1'b0;
    bus.clear_retired = 1'b0;
    bus.mod_sum       = '0;
    bus.mod_cout      = '0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plan 1 and 2
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("p1_active", 32'(bus.active), 32'h3f);
    step(ALL1, ALL1, 1'b1, 1'b0);
    check("p2_sum", 32'(bus.sum), 32'd1);

    // Plan 3: single transient on copy 2
    step(6'b111011, ALL1, 1'b1, 1'b0);
    check("p3_purged", 32'(bus.active), 32'h3b);
    check("p3_n_active", 32'(bus.n_active), 32'd5);
    agree_run(AGREE_CYC - 1);
    check("p3_not_yet", 32'(bus.active), 32'h3b);
    agree_run(1);
    check("p3_back", 32'(bus.active), 32'h3f);

    // Plan 4: interrupted agreement run
    step(6'b111011, ALL1, 1'b1, 1'b0);
    agree_run(4);
    step(6'b111011, ALL1, 1'b1, 1'b0);
    agree_run(AGREE_CYC - 1);
    check("p4_not_yet", 32'(bus.active), 32'h3b);
    agree_run(1);
    check("p4_back", 32'(bus.active), 32'h3f);

    // Plan 5: copy 4 retires after three episodes, then is released
    do_reset();
    for (int e = 0; e < 3; e++) begin
      step(6'b101111, ALL1, 1'b1, 1'b0);
      if (e < 2) agree_run(AGREE_CYC);
    end
    check("p5_retired", 32'(bus.retired), 32'h10);
    agree_run(20);
    check("p5_still_retired", 32'(bus.retired), 32'h10);
    step(ALL1, ALL1, 1'b1, 1'b1);
    check("p5_cleared", 32'(bus.retired), 32'h0);
    agree_run(AGREE_CYC);
    check("p5_back", 32'(bus.active), 32'h3f);

    // Plan 6: wrong majority purges the right copies, then a tie
    do_reset();
    step(6'b110000, 6'b110000, 1'b1, 1'b0);
    check("p6_n4", 32'(bus.n_active), 32'd4);
    check("p6_nofail", 32'(bus.fail), 32'd0);
    step(6'b000011, 6'b000000, 1'b1, 1'b0);
    check("p6_tie_sum", 32'(bus.sum), 32'd0);
    check("p6_n2", 32'(bus.n_active), 32'd2);
    check("p6_fail", 32'(bus.fail), 32'd1);

    // Randomized fault injection
    for (int ph = 0; ph < 60; ph++) begin
      if ($urandom_range(7) == 0) do_reset();
      case ($urandom_range(3))
        0: err_pct = 0;
        1: err_pct = 2;
        2: err_pct = 10;
        default: err_pct = 40;
      endcase
      stuck = ($urandom_range(3) == 0) ? N'($urandom) & N'($urandom) : '0;
      for (int c = 0; c < 40; c++) begin
        ts = 1'($urandom);
        tc = 1'($urandom);
        ms = {N{ts}};
        mc = {N{tc}};
        for (int i = 0; i < N; i++) begin
          if (int'($urandom_range(99)) < err_pct) begin
            if ($urandom_range(1) == 0) ms[i] = ~ms[i];
            else mc[i] = ~mc[i];
          end
        end
        ms  = ms & ~stuck;
        mc  = mc & ~stuck;
        en  = ($urandom_range(9) != 0);
        clr = ($urandom_range(29) == 0);
        step(ms, mc, en, clr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
